// File: rtl/if_stage.sv
// Instruction fetch: PC + program-loadable imem driving the IF/ID register; word at PC appears one cycle later.
// No backpressure handshake: freeze holds PC and IF/ID, flush/branch squash the entry to NOP.
module if_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] NOP        = 32'h0,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic          Br_taken,
    input  logic [31:0]   Br_addr,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   instruction,
    output logic [31:0]   PC_out,
    output logic          valid,
    output logic [31:0]   PC
);

    logic [31:0] imem [IMEM_DEPTH];
    logic        fetch_in_range;
    logic [31:0] fetch_word;
    logic [31:0] pc_next_seq;
    logic [1:0]  unused_br_low;

    // Branch targets are forced word aligned, so the low bits never matter.
    assign unused_br_low  = Br_addr[1:0];

    assign fetch_in_range = (PC[31:AW+2] == '0);
    assign fetch_word     = fetch_in_range ? imem[PC[AW+1:2]] : NOP;
    assign pc_next_seq    = PC + 32'd4;

    // Memory keeps its contents across reset; a write is seen by fetch only from the next cycle.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            PC          <= RESET_PC;
            instruction <= NOP;
            PC_out      <= 32'h0;
            valid       <= 1'b0;
        end else if (Br_taken) begin
            PC          <= {Br_addr[31:2], 2'b00};
            instruction <= NOP;
            PC_out      <= 32'h0;
            valid       <= 1'b0;
        end else if (freeze) begin
            PC          <= PC;
            instruction <= instruction;
            PC_out      <= PC_out;
            valid       <= valid;
        end else if (flush) begin
            PC          <= pc_next_seq;
            instruction <= NOP;
            PC_out      <= 32'h0;
            valid       <= 1'b0;
        end else begin
            PC          <= pc_next_seq;
            instruction <= fetch_word;
            PC_out      <= pc_next_seq;
            valid       <= fetch_in_range;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, freeze, flush, branch, range/wrap, program port and reset.
module tb_if_stage;

    localparam int          DEPTH = 64;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    localparam logic [31:0] WA = 32'hA000_000A;
    localparam logic [31:0] WB = 32'hB000_000B;
    localparam logic [31:0] WC = 32'hC000_000C;
    localparam logic [31:0] WD = 32'hD000_000D;
    localparam logic [31:0] WE = 32'hE000_000E;
    localparam logic [31:0] WF = 32'hF000_000F;
    localparam logic [31:0] WX = 32'h1234_5678;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          flush;
    logic          Br_taken;
    logic [31:0]   Br_addr;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   instruction;
    logic [31:0]   PC_out;
    logic          valid;
    logic [31:0]   PC;

    int checks = 0;
    int errors = 0;

    if_stage #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0),
        .NOP        (NOPW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .Br_taken    (Br_taken),
        .Br_addr     (Br_addr),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .instruction (instruction),
        .PC_out      (PC_out),
        .valid       (valid),
        .PC          (PC)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before inputs change or outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pco,
                               input logic v, input logic [31:0] pc);
        check({tag, ".instr"}, instruction, ins);
        check({tag, ".pc_out"}, PC_out, pco);
        check({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
        check({tag, ".pc"}, PC, pc);
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = addr[AW-1:0];
        imem_wdata = data;
        step();
        imem_we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; Br_taken = 1'b0;
        Br_addr = 32'h0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = 32'h0;
        #1;

        // Program loaded while reset is held.
        load(0, WA); load(1, WB); load(2, WC); load(3, WD); load(4, WE); load(5, WF);
        expect_ifid("reset", NOPW, 32'h0, 1'b0, 32'h0);

        // T1 stream
        rst = 1'b1;
        step(); expect_ifid("t1.a", WA, 32'd4, 1'b1, 32'd4);
        step(); expect_ifid("t1.b", WB, 32'd8, 1'b1, 32'd8);

        // T2 freeze for two cycles with B on the output
        freeze = 1'b1;
        step(); expect_ifid("t2.hold1", WB, 32'd8, 1'b1, 32'd8);
        step(); expect_ifid("t2.hold2", WB, 32'd8, 1'b1, 32'd8);
        freeze = 1'b0;
        step(); expect_ifid("t2.c", WC, 32'd12, 1'b1, 32'd12);
        step(); expect_ifid("t2.d", WD, 32'd16, 1'b1, 32'd16);

        // T3 branch to unaligned 0x13 -> 0x10
        Br_taken = 1'b1; Br_addr = 32'h0000_0013;
        step(); expect_ifid("t3.squash", NOPW, 32'h0, 1'b0, 32'h10);
        Br_taken = 1'b0;
        step(); expect_ifid("t3.e", WE, 32'h14, 1'b1, 32'h14);

        // T6 write imem[5] while PC==20: old word returned, refetch sees new word
        load(5, WX);
        expect_ifid("t6.old", WF, 32'd24, 1'b1, 32'd24);
        Br_taken = 1'b1; Br_addr = 32'd20;
        step(); expect_ifid("t6.redir", NOPW, 32'h0, 1'b0, 32'd20);
        Br_taken = 1'b0;
        step(); expect_ifid("t6.new", WX, 32'd24, 1'b1, 32'd24);

        // T4 branch wins over freeze
        Br_taken = 1'b1; freeze = 1'b1; Br_addr = 32'h8;
        step(); expect_ifid("t4.squash", NOPW, 32'h0, 1'b0, 32'h8);
        Br_taken = 1'b0; freeze = 1'b0;
        step(); expect_ifid("t4.c", WC, 32'd12, 1'b1, 32'd12);

        // Flush drops the fetch of D but PC still advances
        flush = 1'b1;
        step(); expect_ifid("flush", NOPW, 32'h0, 1'b0, 32'd16);
        flush = 1'b0;
        step(); expect_ifid("flush.e", WE, 32'd20, 1'b1, 32'd20);

        // Flush is ignored while frozen
        freeze = 1'b1; flush = 1'b1;
        step(); expect_ifid("frz_flush", WE, 32'd20, 1'b1, 32'd20);
        freeze = 1'b0; flush = 1'b0;

        // T5 out-of-range fetch
        Br_taken = 1'b1; Br_addr = 32'(4 * DEPTH);
        step(); expect_ifid("t5.redir", NOPW, 32'h0, 1'b0, 32'h100);
        Br_taken = 1'b0;
        step(); expect_ifid("t5.oor", NOPW, 32'h104, 1'b0, 32'h104);

        // T5 wrap from 0xFFFFFFFC back to 0
        Br_taken = 1'b1; Br_addr = 32'hFFFF_FFFC;
        step(); expect_ifid("t5.top", NOPW, 32'h0, 1'b0, 32'hFFFF_FFFC);
        Br_taken = 1'b0;
        step(); expect_ifid("t5.wrap", NOPW, 32'h0, 1'b0, 32'h0);
        step(); expect_ifid("t5.a", WA, 32'd4, 1'b1, 32'd4);

        // Reset mid-stream beats branch/freeze; memory survives
        rst = 1'b0; Br_taken = 1'b1; freeze = 1'b1; Br_addr = 32'h40;
        step(); expect_ifid("rst.mid", NOPW, 32'h0, 1'b0, 32'h0);
        rst = 1'b1; Br_taken = 1'b0; freeze = 1'b0;
        step(); expect_ifid("rst.a", WA, 32'd4, 1'b1, 32'd4);
        step(); expect_ifid("rst.b", WB, 32'd8, 1'b1, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
